uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int BYTE_W             = 8;
    localparam int OWNER_W            = 3;
    localparam int DEF_NREQ           = 4;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        START,
        WAIT_DONE
    } arb_state_e;

    // Round-robin pointer step: one past the served index, wrapping at n-1.
    function automatic logic [OWNER_W-1:0] next_ptr(input logic [OWNER_W-1:0] cur, input int n);
        return (int'(cur) >= n - 1) ? '0 : cur + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping from NREQ-1 back to 0.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]    req,
    input  logic [OWNER_W-1:0] ptr,
    output logic               any,
    output logic [OWNER_W-1:0] winner
);

    // Walk the priority order starting at ptr; the first hit wins.
    always_comb begin
        int idx;
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!any && (i == idx) && req[i]) begin
                    any    = 1'b1;
                    winner = OWNER_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding NREQ byte requesters into one UART transmitter.
// Optional watchdog on the end-of-frame handshake: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ           = DEF_NREQ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [BYTE_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]          ack,
    output logic [NREQ-1:0]          sent,
    output logic                     tx_start,
    output logic [BYTE_W-1:0]        tx_data,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic [OWNER_W-1:0]       owner
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic                     tx_timeout
`endif
);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_e                state_q, state_d;
    logic [OWNER_W-1:0]        ptr_q, ptr_d;
    logic [OWNER_W-1:0]        owner_q, owner_d;
    logic [BYTE_W-1:0]         data_q, data_d;
    logic [NREQ-1:0]           ack_q, ack_d;
    logic [NREQ-1:0]           sent_q, sent_d;
    logic                      start_q, start_d;
    logic                      any;
    logic [OWNER_W-1:0]        win;
    logic [BYTE_W-1:0]         sel_data;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      to_q, to_d;
`endif

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (any),
        .winner (win)
    );

    // Byte of the current winner.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (OWNER_W'(i) == win) sel_data = req_data[i*BYTE_W +: BYTE_W];
        end
    end

    // Next-state logic. The winner is picked and latched on the IDLE->GRANT
    // edge so that owner, tx_data and ack are all valid during GRANT; a req
    // that drops before that edge is never seen, and later req/data changes
    // cannot touch the latched frame.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        data_d  = data_q;
        ack_d   = '0;
        sent_d  = '0;
        start_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = GRANT;
                    owner_d = win;
                    data_d  = sel_data;
                    for (int i = 0; i < NREQ; i++) ack_d[i] = (OWNER_W'(i) == win);
                end
            end
            GRANT: state_d = START;
            START: begin
                if (!tx_busy) begin
                    start_d = 1'b1;
                    state_d = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    for (int i = 0; i < NREQ; i++) sent_d[i] = (OWNER_W'(i) == owner_q);
                    ptr_d   = next_ptr(owner_q, NREQ);
                    state_d = IDLE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    to_d    = 1'b1;
                    ptr_d   = next_ptr(owner_q, NREQ);
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            sent_q  <= '0;
            start_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            sent_q  <= sent_d;
            start_q <= start_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign ack      = ack_q;
    assign sent     = sent_q;
    assign tx_start = start_q;
    assign tx_data  = data_q;
    assign owner    = owner_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign tx_timeout = to_q;
`endif

endmodule
